// File: rtl/local_endpoint_sync_pkg.sv
// Shared types for the processor-side local endpoint: FSM state encodings,
// flit header layout and a packing helper for the default flit geometry.
package local_endpoint_sync_pkg;

  localparam int DEF_N  = 32;
  localparam int DEF_XW = 2;
  localparam int DEF_YW = 2;
  localparam int HDR_W  = DEF_XW + DEF_YW + 2;
  localparam int DEF_PW = DEF_N - HDR_W;

  typedef enum logic {TX_IDLE, TX_WAIT_ACK} tx_state_e;
  typedef enum logic {RX_IDLE, RX_HOLD} rx_state_e;

  typedef struct packed {
    logic [DEF_XW-1:0] dst_x;
    logic [DEF_YW-1:0] dst_y;
    logic              deltax;
    logic              deltay;
  } flit_hdr_t;

  // Both FSM states together, so checkers can bind to a single signal.
  typedef struct packed {
    tx_state_e tx_state;
    rx_state_e rx_state;
  } ep_dbg_t;

  function automatic logic [DEF_N-1:0] pack_flit(input logic [DEF_XW-1:0] dst_x,
                                                 input logic [DEF_YW-1:0] dst_y,
                                                 input logic [DEF_PW-1:0] payload,
                                                 input int                srcx,
                                                 input int                srcy);
    flit_hdr_t hdr;
    hdr.dst_x  = dst_x;
    hdr.dst_y  = dst_y;
    hdr.deltax = (int'(dst_x) > srcx);
    hdr.deltay = (int'(dst_y) > srcy);
    return {hdr, payload};
  endfunction

endpackage

// File: rtl/local_endpoint_sync_sync_ff.sv
// Reset-to-zero flop chain used to bring the asynchronous req/ack phases
// into the clk domain.
module sync_ff
  import local_endpoint_sync_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/local_endpoint_sync.sv
// Processor-side endpoint of a mesh router local port: packs requests into flits
// for the router (TX) and presents router flits on a valid/ready port (RX).
//
// Handshakes: tx_valid/tx_ready and rx_valid/rx_ready transfer on a clk edge where
// both are high; out_req/out_ack and in_req/in_ack are 2-phase toggles, a transfer
// is outstanding while req != ack and completes when the receiver makes them equal.
module local_endpoint_sync
  import local_endpoint_sync_pkg::*;
#(
  parameter int N           = 32,
  parameter int SRCX        = 0,
  parameter int SRCY        = 0,
  parameter int XW          = 2,
  parameter int YW          = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [XW-1:0]        tx_dst_x,
  input  logic [YW-1:0]        tx_dst_y,
  input  logic [N-XW-YW-3:0]   tx_payload,
  output logic                 tx_err_self,
  output logic                 out_req,
  input  logic                 out_ack,
  output logic [N-1:0]         out_data,
  input  logic                 in_req,
  output logic                 in_ack,
  input  logic [N-1:0]         in_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [N-1:0]         rx_data
);

  localparam logic [XW-1:0] SRC_X = XW'(SRCX);
  localparam logic [YW-1:0] SRC_Y = YW'(SRCY);

  ep_dbg_t      dbg, dbg_next;
  logic         ack_s, req_s;
  logic         tx_accept, tx_self, rx_capture, rx_release;
  logic [N-1:0] tx_flit;

  sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (out_ack),
    .q   (ack_s)
  );

  sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (in_req),
    .q   (req_s)
  );

  // Default geometry shares the package packer; other geometries pack inline.
  if (N == DEF_N && XW == DEF_XW && YW == DEF_YW) begin : g_pkg_pack
    assign tx_flit = pack_flit(tx_dst_x, tx_dst_y, tx_payload, SRCX, SRCY);
  end else begin : g_param_pack
    assign tx_flit = {tx_dst_x, tx_dst_y, (tx_dst_x > SRC_X), (tx_dst_y > SRC_Y), tx_payload};
  end

  always_comb begin
    dbg_next   = dbg;
    tx_accept  = 1'b0;
    tx_self    = 1'b0;
    rx_capture = 1'b0;
    rx_release = 1'b0;

    unique case (dbg.tx_state)
      TX_IDLE: begin
        if (tx_valid) begin
          if (tx_dst_x == SRC_X && tx_dst_y == SRC_Y) begin
            tx_self = 1'b1;
          end else begin
            tx_accept         = 1'b1;
            dbg_next.tx_state = TX_WAIT_ACK;
          end
        end
      end
      TX_WAIT_ACK: begin
        if (ack_s == out_req) dbg_next.tx_state = TX_IDLE;
      end
    endcase

    unique case (dbg.rx_state)
      RX_IDLE: begin
        if (req_s != in_ack) begin
          rx_capture        = 1'b1;
          dbg_next.rx_state = RX_HOLD;
        end
      end
      RX_HOLD: begin
        if (rx_ready) begin
          rx_release        = 1'b1;
          dbg_next.rx_state = RX_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg         <= '{tx_state: TX_IDLE, rx_state: RX_IDLE};
      tx_err_self <= 1'b0;
      out_req     <= 1'b0;
      out_data    <= '0;
      in_ack      <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
    end else begin
      dbg         <= dbg_next;
      tx_err_self <= tx_self;
      // Data and req change on the same edge; out_data then stays frozen
      // until the ack phase comes back, which gives the bundled-data setup.
      if (tx_accept) begin
        out_data <= tx_flit;
        out_req  <= ~out_req;
      end
      if (rx_capture) begin
        rx_data  <= in_data;
        rx_valid <= 1'b1;
      end
      if (rx_release) begin
        rx_valid <= 1'b0;
        in_ack   <= ~in_ack;
      end
    end
  end

  assign tx_ready = (dbg.tx_state == TX_IDLE);

endmodule

// File: tb/tb_local_endpoint_sync.sv
// Directed bench for local_endpoint_sync with behavioural 2-phase router models
// on both the TX and RX sides (random 0-7 cycle response delay).
module tb_local_endpoint_sync;

  localparam int N  = 32;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam int PW = N - XW - YW - 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_valid;
  logic          tx_ready;
  logic [XW-1:0] tx_dst_x;
  logic [YW-1:0] tx_dst_y;
  logic [PW-1:0] tx_payload;
  logic          tx_err_self;
  logic          out_req;
  logic          out_ack;
  logic [N-1:0]  out_data;
  logic          in_req;
  logic          in_ack;
  logic [N-1:0]  in_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [N-1:0]  rx_data;

  int tests = 0;
  int fails = 0;

  logic [N-1:0] tx_got_q[$];
  logic [N-1:0] tx_exp_q[$];
  logic [N-1:0] rx_send_q[$];
  logic [N-1:0] rx_exp_q[$];
  logic [N-1:0] rx_got_q[$];
  bit           tx_auto = 1'b1;
  int           ack_toggles = 0;

  always #5 clk = ~clk;

  local_endpoint_sync #(
    .N(N), .SRCX(1), .SRCY(1), .XW(XW), .YW(YW), .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_dst_x    (tx_dst_x),
    .tx_dst_y    (tx_dst_y),
    .tx_payload  (tx_payload),
    .tx_err_self (tx_err_self),
    .out_req     (out_req),
    .out_ack     (out_ack),
    .out_data    (out_data),
    .in_req      (in_req),
    .in_ack      (in_ack),
    .in_data     (in_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data)
  );

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected flit for the node at (1,1).
  function automatic logic [N-1:0] mk_flit(input logic [1:0] dx, input logic [1:0] dy,
                                           input logic [PW-1:0] pl);
    return {dx, dy, (dx > 2'd1), (dy > 2'd1), pl};
  endfunction

  task automatic wait_tx_ready(input int budget, input string tag, output int waited);
    waited = 0;
    while (tx_ready !== 1'b1 && waited < budget) begin
      @(posedge clk); #1;
      waited++;
    end
    check(tag, {31'b0, tx_ready}, 1);
  endtask

  task automatic send_tx(input logic [1:0] dx, input logic [1:0] dy, input logic [PW-1:0] pl);
    int w;
    wait_tx_ready(200, "tx_ready_before_send", w);
    tx_dst_x   = dx;
    tx_dst_y   = dy;
    tx_payload = pl;
    tx_valid   = 1'b1;
    @(posedge clk); #1;
    tx_valid   = 1'b0;
  endtask

  // Router local input: records each flit and acks after a random delay.
  initial begin : tx_router
    bit           pending;
    int           dly;
    logic [N-1:0] held;
    pending = 1'b0;
    dly     = 0;
    held    = '0;
    out_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        out_ack = 1'b0;
        pending = 1'b0;
      end else if (tx_auto && out_req !== out_ack) begin
        if (!pending) begin
          pending = 1'b1;
          held    = out_data;
          tx_got_q.push_back(out_data);
          dly     = $urandom_range(0, 7);
        end
        check("out_data_stable", out_data, held);
        if (dly == 0) begin
          out_ack = out_req;
          pending = 1'b0;
        end else begin
          dly--;
        end
      end
    end
  end

  // Router local output: sends queued flits, one outstanding at a time.
  initial begin : rx_router
    int dly;
    in_req  = 1'b0;
    in_data = '0;
    dly     = $urandom_range(0, 7);
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        in_req = 1'b0;
        rx_send_q.delete();
      end else if (in_req === in_ack && rx_send_q.size() > 0) begin
        if (dly == 0) begin
          in_data = rx_send_q.pop_front();
          in_req  = ~in_req;
          dly     = $urandom_range(0, 7);
        end else begin
          dly--;
        end
      end
    end
  end

  initial begin : rx_monitor
    logic last;
    last = 1'b0;
    forever begin
      @(negedge clk);
      if (in_ack !== last) begin
        if (!rst) ack_toggles++;
        last = in_ack;
      end
      if (!rst && rx_valid && rx_ready) rx_got_q.push_back(rx_data);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int           w, n;
    logic         req_before;
    logic [1:0]   dx, dy;
    logic [N-1:0] f;

    // 1: reset, then idle
    rst = 1'b1; tx_valid = 1'b0; tx_dst_x = '0; tx_dst_y = '0; tx_payload = '0; rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("t1_out_req", {31'b0, out_req}, 0);
    check("t1_in_ack", {31'b0, in_ack}, 0);
    check("t1_rx_valid", {31'b0, rx_valid}, 0);
    check("t1_tx_ready", {31'b0, tx_ready}, 1);
    check("t1_tx_err_self", {31'b0, tx_err_self}, 0);
    check("t1_out_data", out_data, 0);
    check("t1_rx_data", rx_data, 0);

    // 2: dst(3,0) from node (1,1)
    tx_got_q.delete();
    send_tx(2'd3, 2'd0, 26'h1234);
    check("t2_out_req", {31'b0, out_req}, 1);
    check("t2_out_data", out_data, 32'hC800_1234);
    check("t2_tx_ready_low", {31'b0, tx_ready}, 0);
    wait_tx_ready(100, "t2_tx_ready_high", w);
    check("t2_min_wait", {31'b0, (w >= 3)}, 1);
    check("t2_router_count", tx_got_q.size(), 1);
    check("t2_router_flit", tx_got_q.size() > 0 ? tx_got_q[0] : {N{1'bx}}, 32'hC800_1234);

    // 3: self-addressed packet is dropped
    req_before = out_req;
    send_tx(2'd1, 2'd1, 26'h55);
    check("t3_err_pulse", {31'b0, tx_err_self}, 1);
    check("t3_tx_ready", {31'b0, tx_ready}, 1);
    @(posedge clk); #1;
    check("t3_err_clear", {31'b0, tx_err_self}, 0);
    repeat (10) begin @(posedge clk); #1; end
    check("t3_out_req_same", {31'b0, out_req}, {31'b0, req_before});
    check("t3_router_count", tx_got_q.size(), 1);

    // 4: three flits queued with rx_ready held low
    rx_got_q.delete();
    ack_toggles = 0;
    rx_send_q.push_back(32'hA5A5_0001);
    rx_send_q.push_back(32'h5A5A_0002);
    rx_send_q.push_back(32'h0F0F_0003);
    repeat (20) begin @(posedge clk); #1; end
    check("t4_rx_valid_held", {31'b0, rx_valid}, 1);
    check("t4_rx_data_first", rx_data, 32'hA5A5_0001);
    check("t4_in_ack_held", {31'b0, in_ack}, 0);
    check("t4_no_toggle", ack_toggles, 0);
    rx_ready = 1'b1;
    n = 0;
    while (rx_got_q.size() < 3 && n < 200) begin @(posedge clk); #1; n++; end
    repeat (2) begin @(posedge clk); #1; end
    rx_ready = 1'b0;
    check("t4_rx_count", rx_got_q.size(), 3);
    check("t4_flit0", rx_got_q.size() > 0 ? rx_got_q[0] : {N{1'bx}}, 32'hA5A5_0001);
    check("t4_flit1", rx_got_q.size() > 1 ? rx_got_q[1] : {N{1'bx}}, 32'h5A5A_0002);
    check("t4_flit2", rx_got_q.size() > 2 ? rx_got_q[2] : {N{1'bx}}, 32'h0F0F_0003);
    check("t4_toggles", ack_toggles, 3);
    check("t4_rx_valid_low", {31'b0, rx_valid}, 0);

    // 5: concurrent 50-flit streams in both directions
    tx_got_q.delete(); tx_exp_q.delete(); rx_exp_q.delete(); rx_got_q.delete();
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          dx = 2'($urandom_range(0, 3));
          dy = 2'($urandom_range(0, 3));
          if (dx == 2'd1 && dy == 2'd1) dx = 2'd0;
          tx_exp_q.push_back(mk_flit(dx, dy, PW'($urandom)));
          send_tx(dx, dy, tx_exp_q[i][PW-1:0]);
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
      begin
        for (int i = 0; i < 50; i++) begin
          f = $urandom;
          rx_exp_q.push_back(f);
          rx_send_q.push_back(f);
        end
      end
      begin
        int m;
        m = 0;
        while (rx_got_q.size() < 50 && m < 5000) begin
          rx_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          m++;
        end
        rx_ready = 1'b0;
      end
    join
    wait_tx_ready(100, "t5_tx_drain", w);
    repeat (5) begin @(posedge clk); #1; end
    check("t5_tx_count", tx_got_q.size(), 50);
    check("t5_rx_count", rx_got_q.size(), 50);
    for (int i = 0; i < 50; i++) begin
      check($sformatf("t5_tx_flit_%0d", i), i < tx_got_q.size() ? tx_got_q[i] : {N{1'bx}}, tx_exp_q[i]);
      check($sformatf("t5_rx_flit_%0d", i), i < rx_got_q.size() ? rx_got_q[i] : {N{1'bx}}, rx_exp_q[i]);
    end

    // 6: reset while TX waits for ack and RX holds a flit
    tx_auto = 1'b0;
    send_tx(2'd2, 2'd3, 26'h2AB_CDEF);
    repeat (4) begin @(posedge clk); #1; end
    check("t6_in_wait_ack", {31'b0, tx_ready}, 0);
    rx_send_q.push_back(32'hDEAD_BEEF);
    n = 0;
    while (rx_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check("t6_in_hold", {31'b0, rx_valid}, 1);
    check("t6_in_ack_odd", {31'b0, in_ack}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_out_req", {31'b0, out_req}, 0);
    check("t6_out_data", out_data, 0);
    check("t6_in_ack", {31'b0, in_ack}, 0);
    check("t6_rx_valid", {31'b0, rx_valid}, 0);
    check("t6_rx_data", rx_data, 0);
    check("t6_tx_ready", {31'b0, tx_ready}, 1);
    check("t6_tx_err_self", {31'b0, tx_err_self}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tx_auto = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("t6_post_out_req", {31'b0, out_req}, 0);
    check("t6_post_rx_valid", {31'b0, rx_valid}, 0);
    tx_got_q.delete();
    send_tx(2'd0, 2'd0, 26'h0ABCDE);
    wait_tx_ready(100, "t6_recover_ready", w);
    check("t6_recover_flit", tx_got_q.size() > 0 ? tx_got_q[0] : {N{1'bx}}, 32'h000A_BCDE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
